// File: rtl/math_pkg.sv
// Shared widths for the carry-lookahead adder datapath.
package math_pkg;
   localparam int unsigned CLA_SLICE_W = 4;
   localparam int unsigned CLA_WIDTH   = 16;
   localparam int unsigned CLA_SLICES  = 4;
endpackage

// File: rtl/cla16_reg_if.sv
// Operand/result bundle for the registered 16-bit CLA.
interface cla16_reg_if;
   import math_pkg::*;

   logic [CLA_WIDTH-1:0] a;
   logic [CLA_WIDTH-1:0] b;
   logic                 cIn;
   logic [CLA_WIDTH-1:0] s;
   logic                 cOut;
   logic                 pg;
   logic                 gg;

   modport master (output a, b, cIn, input s, cOut, pg, gg);
   modport slave  (input a, b, cIn, output s, cOut, pg, gg);
endinterface

// File: rtl/cla4.sv
// 4-bit carry-lookahead slice with group propagate/generate outputs.
module cla4
   import math_pkg::*;
(
   input  logic [CLA_SLICE_W-1:0] a,
   input  logic [CLA_SLICE_W-1:0] b,
   input  logic                   cIn,
   output logic [CLA_SLICE_W-1:0] s,
   output logic                   cOut,
   output logic                   pg,
   output logic                   gg
);
   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   always_comb begin
      p = a ^ b;
      g = a & b;
      // carries written as full sum-of-products so no term depends on a lower carry
      c[0] = cIn;
      c[1] = g[0] | (p[0] & cIn);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cIn);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cIn);
      pg   = &p;
      gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      cOut = gg | (pg & cIn);
      s    = p ^ c;
   end
endmodule

// File: rtl/lcu.sv
// Lookahead carry unit combining four slice P/G pairs.
module lcu
   import math_pkg::*;
(
   input  logic [CLA_SLICES-1:0] p,
   input  logic [CLA_SLICES-1:0] g,
   input  logic                  cIn,
   output logic [3:1]            c,
   output logic                  pg,
   output logic                  gg,
   output logic                  cOut
);
   always_comb begin
      c[1] = g[0] | (p[0] & cIn);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cIn);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cIn);
      pg   = &p;
      gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      cOut = gg | (pg & cIn);
   end
endmodule

// File: rtl/cla16_reg.sv
// Registered 16-bit adder: four cla4 slices, one lcu, one output stage.
module cla16_reg
   import math_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   cla16_reg_if.slave bus
);
   logic [CLA_WIDTH-1:0]  a_w;
   logic [CLA_WIDTH-1:0]  b_w;
   logic [CLA_WIDTH-1:0]  sum_w;
   logic [CLA_SLICES-1:0] sp_w;
   logic [CLA_SLICES-1:0] sg_w;
   logic [CLA_SLICES-1:0] scin_w;
   logic [CLA_SLICES-1:0] slice_co_unused;
   logic [3:1]            lcu_c_w;
   logic                  lcu_pg_w;
   logic                  lcu_gg_w;
   logic                  lcu_co_w;

   logic [CLA_WIDTH-1:0]  s_d,    s_q;
   logic                  cout_d, cout_q;
   logic                  pg_d,   pg_q;
   logic                  gg_d,   gg_q;

   assign a_w    = bus.a;
   assign b_w    = bus.b;
   assign scin_w = {lcu_c_w, bus.cIn};

   for (genvar k = 0; k < CLA_SLICES; k++) begin : g_slice
      cla4 u_cla4 (
         .a    (a_w[k*CLA_SLICE_W +: CLA_SLICE_W]),
         .b    (b_w[k*CLA_SLICE_W +: CLA_SLICE_W]),
         .cIn  (scin_w[k]),
         .s    (sum_w[k*CLA_SLICE_W +: CLA_SLICE_W]),
         .cOut (slice_co_unused[k]),
         .pg   (sp_w[k]),
         .gg   (sg_w[k])
      );
   end

   lcu u_lcu (
      .p    (sp_w),
      .g    (sg_w),
      .cIn  (bus.cIn),
      .c    (lcu_c_w),
      .pg   (lcu_pg_w),
      .gg   (lcu_gg_w),
      .cOut (lcu_co_w)
   );

   always_comb begin
      s_d    = sum_w;
      cout_d = lcu_co_w;
      pg_d   = lcu_pg_w;
      gg_d   = lcu_gg_w;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_q    <= '0;
         cout_q <= 1'b0;
         pg_q   <= 1'b0;
         gg_q   <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
         pg_q   <= pg_d;
         gg_q   <= gg_d;
      end
   end

   assign bus.s    = s_q;
   assign bus.cOut = cout_q;
   assign bus.pg   = pg_q;
   assign bus.gg   = gg_q;
endmodule

// File: tb/tb_cla16_reg.sv
// Directed and random checks of cla16_reg against hand-computed sums.
module tb_cla16_reg;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   cla16_reg_if bus ();

   cla16_reg dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c);
      bus.a   = a;
      bus.b   = b;
      bus.cIn = c;
   endtask

   // drive operands, take one edge, check all four registered outputs
   task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic c, input logic [15:0] es, input logic eco,
                     input logic epg, input logic egg);
      drive(a, b, c);
      @(posedge clk);
      #1;
      chk({tag, ".s"},    {16'h0, bus.s},    {16'h0, es});
      chk({tag, ".cOut"}, {31'h0, bus.cOut}, {31'h0, eco});
      chk({tag, ".pg"},   {31'h0, bus.pg},   {31'h0, epg});
      chk({tag, ".gg"},   {31'h0, bus.gg},   {31'h0, egg});
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rc;
      logic [16:0] t, t0;

      reset = 1'b1;
      drive(16'hFFFF, 16'hFFFF, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.s",    {16'h0, bus.s}, 32'h0);
      chk("rst.flag", {29'h0, bus.cOut, bus.pg, bus.gg}, 32'h0);
      reset = 1'b0;

      op("add1",   16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
      op("add2",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);
      op("full1",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      op("full2",  16'hC000, 16'h4CA8, 1'b0, 16'h0CA8, 1'b1, 1'b0, 1'b1);
      op("zero0",  16'hCCCC, 16'h3334, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      op("max0",   16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1);
      op("cin1",   16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
      op("cin2",   16'h7FFE, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
      op("cinpg1", 16'hFFFE, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
      op("cin4",   16'hC000, 16'h4CA7, 1'b1, 16'h0CA8, 1'b1, 1'b0, 1'b1);
      op("cinpg2", 16'hCCCC, 16'h3333, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
      op("max1",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
      op("pgnoc",  16'hCCCC, 16'h3333, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);

      // new operands must not reach s before the next edge
      drive(16'h1234, 16'h1111, 1'b0);
      #3;
      chk("lat.hold", {16'h0, bus.s}, 32'h0000FFFF);
      @(posedge clk);
      #1;
      chk("lat.s", {16'h0, bus.s}, 32'h00002345);
      drive(16'h8000, 16'h8000, 1'b1);
      @(posedge clk);
      #1;
      chk("b2b.s",  {16'h0, bus.s}, 32'h00000001);
      chk("b2b.co", {31'h0, bus.cOut}, 32'h1);

      reset = 1'b1;
      drive(16'hFFFF, 16'hFFFF, 1'b0);
      @(posedge clk);
      #1;
      chk("rstpri.s",    {16'h0, bus.s}, 32'h0);
      chk("rstpri.flag", {29'h0, bus.cOut, bus.pg, bus.gg}, 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("postrst.s", {16'h0, bus.s}, 32'h0000FFFE);

      for (int i = 0; i < 10000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         t  = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
         t0 = {1'b0, ra} + {1'b0, rb};
         drive(ra, rb, rc);
         @(posedge clk);
         #1;
         chk("rnd.sum", {15'h0, bus.cOut, bus.s}, {15'h0, t});
         chk("rnd.pggg", {30'h0, bus.pg, bus.gg}, {30'h0, &(ra ^ rb), t0[16]});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
